// File: rtl/sha1_message_loader_if.sv
// ----------------------------------------------------------------------------
// sha1_message_loader_if
//   Bundles the signals around the SHA-1 message loader. These are the
//   host-side byte stream, the dpsram port-A write port and the start/done
//   handshake with the SHA-1 core.
//
//   slave  : view of the loader itself (drives byte_ready, port A, start,
//            result, busy).
//   master : view of the surrounding environment (host, dpsram, core).
//
//   Signals:
//     load_start, base_addr                 host -> loader, message request
//     byte_valid, byte_data, byte_last      host -> loader, byte stream
//     byte_ready                            loader -> host
//     port_A_clk/addr/data_in/we            loader -> dpsram port A
//     start_hash, message_addr/size         loader -> SHA-1 core
//     hash_done, hash_in                    SHA-1 core -> loader
//     result, result_valid, busy            loader -> host
// ----------------------------------------------------------------------------
interface sha1_message_loader_if #(
    parameter int ADDR_W = 16
);
    logic              load_start;
    logic [31:0]       base_addr;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_last;
    logic              byte_ready;
    logic              port_A_clk;
    logic [ADDR_W-1:0] port_A_addr;
    logic [31:0]       port_A_data_in;
    logic              port_A_we;
    logic              start_hash;
    logic [31:0]       message_addr;
    logic [31:0]       message_size;
    logic              hash_done;
    logic [159:0]      hash_in;
    logic [159:0]      result;
    logic              result_valid;
    logic              busy;

    modport slave (
        input  load_start, base_addr, byte_valid, byte_data, byte_last,
        input  hash_done, hash_in,
        output byte_ready, port_A_clk, port_A_addr, port_A_data_in, port_A_we,
        output start_hash, message_addr, message_size,
        output result, result_valid, busy
    );

    modport master (
        output load_start, base_addr, byte_valid, byte_data, byte_last,
        output hash_done, hash_in,
        input  byte_ready, port_A_clk, port_A_addr, port_A_data_in, port_A_we,
        input  start_hash, message_addr, message_size,
        input  result, result_valid, busy
    );
endinterface

// File: rtl/sha1_message_loader.sv
// ----------------------------------------------------------------------------
// sha1_message_loader
//   Writer side of the SHA-1 core's dpsram port A. It packs an incoming byte
//   stream big-endian into 32-bit words and writes them to dpsram starting at
//   the latched base address. It then pulses start_hash with the message
//   address and size, waits for the core's done and captures the 160-bit hash.
//
//   Ports:
//     clk    system clock (also forwarded as port_A_clk)
//     reset  asynchronous, active-high
//     bus    sha1_message_loader_if.slave, which holds all handshake, dpsram
//            and core signals
//
//   Timing: the final byte is accepted at edge N, port_A_we is high in cycle
//   N+1 and start_hash is high in cycle N+2.
// ----------------------------------------------------------------------------
module sha1_message_loader #(
    parameter int ADDR_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    sha1_message_loader_if.slave     bus
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_FILL      = 2'd1;
    localparam logic [1:0] S_START     = 2'd2;
    localparam logic [1:0] S_WAIT_HASH = 2'd3;

    logic [1:0]        r_state;
    logic [31:0]       r_pack;      // partially filled word, unfilled bytes 0
    logic [1:0]        r_bidx;      // byte position inside the current word
    logic [ADDR_W-1:0] r_waddr;     // address of the word being filled
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic              r_we;
    logic              r_start;
    logic [31:0]       r_msg_addr;
    logic [31:0]       r_size;
    logic [159:0]      r_result;
    logic              r_res_valid;
    logic              r_busy;

    logic              w_accept;
    logic              w_flush;
    logic [31:0]       w_word;

    // byte_ready is combinational on state so that it drops together with
    // an asynchronous reset.
    assign bus.byte_ready = (r_state == S_FILL);
    assign w_accept       = (r_state == S_FILL) && bus.byte_valid;
    // Flush on the 4th byte of a word or on the last byte of the message.
    // Each accepted byte causes at most one write, so port A never stalls
    // the stream.
    assign w_flush        = w_accept && ((r_bidx == 2'd3) || bus.byte_last);

    // Merge the incoming byte into the packing register (big-endian).
    always_comb begin
        w_word = r_pack;
        case (r_bidx)
            2'd0:    w_word[31:24] = bus.byte_data;
            2'd1:    w_word[23:16] = bus.byte_data;
            2'd2:    w_word[15:8]  = bus.byte_data;
            default: w_word[7:0]   = bus.byte_data;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pack      <= '0;
            r_bidx      <= '0;
            r_waddr     <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_we        <= 1'b0;
            r_start     <= 1'b0;
            r_msg_addr  <= '0;
            r_size      <= '0;
            r_result    <= '0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // Write enable and start are single-cycle strobes.
            r_we    <= 1'b0;
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.load_start) begin
                        r_msg_addr  <= bus.base_addr;
                        r_waddr     <= bus.base_addr[ADDR_W-1:0];
                        r_size      <= '0;
                        r_pack      <= '0;
                        r_bidx      <= '0;
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (w_accept) begin
                        r_size <= r_size + 32'd1;
                        if (w_flush) begin
                            r_we    <= 1'b1;
                            r_addr  <= r_waddr;
                            r_data  <= w_word;
                            // Address arithmetic wraps mod 2^ADDR_W.
                            r_waddr <= r_waddr + ADDR_W'(4);
                            r_pack  <= '0;
                            r_bidx  <= '0;
                        end else begin
                            r_pack  <= w_word;
                            r_bidx  <= r_bidx + 2'd1;
                        end
                        if (bus.byte_last)
                            r_state <= S_START;
                    end
                end
                S_START: begin
                    // This is the cycle of the final write. start_hash
                    // therefore shows in the next cycle.
                    r_start <= 1'b1;
                    r_state <= S_WAIT_HASH;
                end
                default: begin
                    if (bus.hash_done) begin
                        r_result    <= bus.hash_in;
                        r_res_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.port_A_clk     = clk;
    assign bus.port_A_addr    = r_addr;
    assign bus.port_A_data_in = r_data;
    assign bus.port_A_we      = r_we;
    assign bus.start_hash     = r_start;
    assign bus.message_addr   = r_msg_addr;
    assign bus.message_size   = r_size;
    assign bus.result         = r_result;
    assign bus.result_valid   = r_res_valid;
    assign bus.busy           = r_busy;

endmodule

// File: tb/tb_sha1_message_loader.sv
// ----------------------------------------------------------------------------
// tb_sha1_message_loader
//   Directed bench for sha1_message_loader. A negedge monitor logs every
//   port-A write (addr, data, cycle) and every start_hash cycle. Each test
//   then compares the logs against hand-computed values.
// ----------------------------------------------------------------------------
module tb_sha1_message_loader;

    localparam logic [159:0] HASH_ABC =
        160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   acc;
    int   acc_d;

    logic [15:0] wa[$];
    logic [31:0] wd[$];
    int          wc[$];
    int          sc[$];

    sha1_message_loader_if #(.ADDR_W(16)) bus();

    sha1_message_loader #(.ADDR_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.port_A_we) begin
            wa.push_back(bus.port_A_addr);
            wd.push_back(bus.port_A_data_in);
            wc.push_back(cyc);
        end
        if (bus.start_hash) sc.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_log();
        wa.delete(); wd.delete(); wc.delete(); sc.delete();
    endtask

    task automatic pulse_load(input logic [31:0] base);
        @(negedge clk);
        bus.load_start = 1'b1;
        bus.base_addr  = base;
        @(posedge clk);
        #1 bus.load_start = 1'b0;
    endtask

    task automatic load_msg(input logic [31:0] base);
        clr_log();
        pulse_load(base);
        chk("busy_on_load", bus.busy, 1'b1);
        chk("msg_addr", bus.message_addr, base);
        chk("rvalid_clr", bus.result_valid, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        bus.byte_last  = last;
        #1 chk("byte_ready", bus.byte_ready, 1'b1);
        @(posedge clk);
        #1;
        acc = cyc;
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        while (sc.size() == 0 && n < 20) begin
            @(negedge clk);
            #1 n++;
        end
        if (sc.size() == 0) chk("start_timeout", 1'b0, 1'b1);
    endtask

    task automatic do_hash(input logic [159:0] h);
        @(negedge clk);
        bus.hash_done = 1'b1;
        bus.hash_in   = h;
        @(posedge clk);
        #1 bus.hash_done = 1'b0;
        chk("result", bus.result, h);
        chk("result_valid", bus.result_valid, 1'b1);
        chk("busy_done", bus.busy, 1'b0);
    endtask

    task automatic run_abc(input logic [31:0] base);
        load_msg(base);
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        wait_start();
        chk("abc_nwr", wa.size(), 1);
        if (wa.size() == 1) begin
            chk("abc_addr", wa[0], base[15:0]);
            chk("abc_data", wd[0], 32'h61626300);
            chk("abc_we_cyc", wc[0], acc);
        end
        chk("abc_nstart", sc.size(), 1);
        if (sc.size() == 1) chk("abc_start_cyc", sc[0], acc + 1);
        chk("abc_size", bus.message_size, 3);
        chk("abc_maddr", bus.message_addr, base);
        do_hash(HASH_ABC);
    endtask

    initial begin
        bus.load_start = 1'b0;
        bus.base_addr  = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;
        bus.byte_last  = 1'b0;
        bus.hash_done  = 1'b0;
        bus.hash_in    = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", bus.byte_ready, 1'b0);
        chk("rst_we", bus.port_A_we, 1'b0);
        chk("rst_addr", bus.port_A_addr, 16'h0);
        chk("rst_data", bus.port_A_data_in, 32'h0);
        chk("rst_start", bus.start_hash, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_rvalid", bus.result_valid, 1'b0);
        chk("rst_result", bus.result, 160'h0);
        chk("rst_size", bus.message_size, 32'h0);
        chk("rst_maddr", bus.message_addr, 32'h0);
        chk("portA_clk_lo", bus.port_A_clk, 1'b0);
        reset = 1'b0;

        // Test 1: "abc"
        run_abc(32'h100);

        // Test 2: "abcde" at 0x200, continuous valid
        load_msg(32'h200);
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b0);
        send_byte(8'h64, 1'b0);
        acc_d = acc;
        send_byte(8'h65, 1'b1);
        wait_start();
        chk("t2_nwr", wa.size(), 2);
        if (wa.size() == 2) begin
            chk("t2_addr0", wa[0], 16'h0200);
            chk("t2_data0", wd[0], 32'h61626364);
            chk("t2_cyc0", wc[0], acc_d);
            chk("t2_addr1", wa[1], 16'h0204);
            chk("t2_data1", wd[1], 32'h65000000);
        end
        if (sc.size() == 1) chk("t2_start_cyc", sc[0], acc + 1);
        chk("t2_size", bus.message_size, 5);
        do_hash(160'h1234);

        // Test 3: "abcd" with 3-cycle gaps
        load_msg(32'h300);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'h61 + 8'(i), i == 3);
            if (i != 3) repeat (3) @(negedge clk);
        end
        wait_start();
        chk("t3_nwr", wa.size(), 1);
        if (wa.size() == 1) begin
            chk("t3_addr", wa[0], 16'h0300);
            chk("t3_data", wd[0], 32'h61626364);
        end
        chk("t3_size", bus.message_size, 4);
        do_hash(160'h5678);

        // Test 4: address wrap at 0xFFFC
        load_msg(32'hFFFC);
        for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
        wait_start();
        chk("t4_nwr", wa.size(), 2);
        if (wa.size() == 2) begin
            chk("t4_addr0", wa[0], 16'hFFFC);
            chk("t4_data0", wd[0], 32'h01020304);
            chk("t4_addr1", wa[1], 16'h0000);
            chk("t4_data1", wd[1], 32'h05060708);
        end
        chk("t4_size", bus.message_size, 8);
        do_hash(160'h9abc);

        // Test 5: load_start in FILL / WAIT_HASH, hash_done in FILL
        load_msg(32'h500);
        pulse_load(32'h999);
        chk("t5_maddr_fill", bus.message_addr, 32'h500);
        @(negedge clk);
        bus.hash_done = 1'b1;
        bus.hash_in   = 160'hdead;
        @(posedge clk);
        #1 bus.hash_done = 1'b0;
        chk("t5_rvalid_fill", bus.result_valid, 1'b0);
        chk("t5_busy_fill", bus.busy, 1'b1);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b1);
        wait_start();
        pulse_load(32'h777);
        chk("t5_maddr_wait", bus.message_addr, 32'h500);
        chk("t5_busy_wait", bus.busy, 1'b1);
        chk("t5_nwr", wa.size(), 1);
        if (wa.size() == 1) chk("t5_data", wd[0], 32'h11220000);
        do_hash(160'hbeef);

        // Test 6: reset after 2 of 6 bytes
        load_msg(32'h600);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("t6_busy", bus.busy, 1'b0);
        chk("t6_ready", bus.byte_ready, 1'b0);
        chk("t6_we", bus.port_A_we, 1'b0);
        chk("t6_maddr", bus.message_addr, 32'h0);
        chk("t6_size", bus.message_size, 32'h0);
        chk("t6_result", bus.result, 160'h0);
        chk("t6_rvalid", bus.result_valid, 1'b0);
        clr_log();
        for (int i = 3; i <= 6; i++) begin
            @(negedge clk);
            if (i == 5) reset = 1'b0;
            bus.byte_valid = 1'b1;
            bus.byte_data  = 8'(i);
            bus.byte_last  = (i == 6);
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("t6_nwr", wa.size(), 0);
        chk("t6_nstart", sc.size(), 0);
        chk("t6_busy_after", bus.busy, 1'b0);
        run_abc(32'h100);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    // Hard stop if the flow ever stalls.
    initial begin
        #200000;
        $display("FAIL global_timeout: got stall expected finish");
        $fatal(1);
    end

endmodule

// File: doc/sha1_message_loader.md
Name: sha1_message_loader

Overview:
- Writer side of the SHA-1 hash core's dpsram port-A interface.
- Accepts a byte stream and packs it big-endian into 32-bit words. Writes the words into dpsram through port A at a given base address.
- Then pulses start_hash with message_addr/message_size for the hash core, waits for the core's done, and captures the 160-bit result.
- Sits between the host-side byte source and the dpsram/SHA-1 core pair.

Parameters:
- ADDR_W, 16, width of port_A_addr; word addresses are byte addresses stepping by 4, wrapping mod 2^ADDR_W.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- load_start  input  1  one-cycle request to begin a new message; accepted only in IDLE.
- base_addr  input  32  dpsram byte address of the first message word; latched on accepted load_start.
- byte_valid  input  1  byte_data valid.
- byte_data  input  8  message byte.
- byte_last  input  1  qualifies the final byte of the message (valid with byte_valid).
- byte_ready  output  1  loader accepts a byte this cycle.
- port_A_clk  output  1  dpsram clock, driven directly by clk.
- port_A_addr  output  ADDR_W  dpsram address.
- port_A_data_in  output  32  write data to dpsram.
- port_A_we  output  1  dpsram write enable.
- start_hash  output  1  one-cycle start pulse to the SHA-1 core.
- message_addr  output  32  message start address to the core (latched base_addr).
- message_size  output  32  message length in bytes to the core.
- hash_done  input  1  done from the SHA-1 core.
- hash_in  input  160  hash from the SHA-1 core.
- result  output  160  captured hash.
- result_valid  output  1  result holds the hash of the last loaded message.
- busy  output  1  high from accepted load_start until the result is captured.

Behaviour:
- Reset (async, active-high) values:
  - All outputs 0 except port_A_clk, which follows clk.
  - FSM goes to IDLE, byte counter and packing register are cleared.
  - Reset mid-operation aborts with no further writes. Any in-flight port_A_we drops immediately.
- FSM states: IDLE, FILL, START, WAIT_HASH.
- IDLE:
  - byte_ready=0.
  - load_start=1 latches base_addr into message_addr, clears the byte count, clears result_valid, sets busy=1, and moves to FILL next cycle.
- FILL:
  - byte_ready=1. A byte is accepted on a clock edge with byte_valid&byte_ready.
  - Packing: byte k of a word (k=0..3) goes to bits [31-8k:24-8k]. Unfilled bytes are 0.
  - Word write: when the 4th byte of a word or a byte with byte_last is accepted at edge N, the cycle after N drives port_A_we=1, port_A_data_in=packed word, and port_A_addr = base_addr[ADDR_W-1:0] + 4*word_index (wraps).
  - Outside write cycles: port_A_we=0; addr/data hold their last values.
  - One write per accepted byte at most, so byte_ready never deasserts in FILL.
  - message_size counts accepted bytes (32-bit).
  - byte_last accepted -> START, entered in the same cycle as the final write.
- START:
  - The cycle after the final write, start_hash=1 for exactly one cycle.
  - message_size is final and stable from this cycle until the next accepted load_start.
  - Next state is WAIT_HASH.
- WAIT_HASH:
  - byte_ready=0, start_hash=0.
  - On hash_done=1: result<=hash_in, result_valid<=1, busy<=0, FSM goes to IDLE.
  - hash_done in any other state is ignored.
- Latency: final byte accepted at edge N -> port_A_we high in cycle N+1 -> start_hash high in cycle N+2.
- load_start while not in IDLE is ignored.
- byte_valid outside FILL is ignored (byte_ready=0).
- A message is at least 1 byte.
- result/result_valid hold until the next accepted load_start or reset.

Test Plan:
- base_addr=0x100, bytes "abc" (last on 'c'):
  - one write, addr 0x0100, data 0x61626300;
  - start_hash pulse two cycles after 'c';
  - message_addr 0x100, message_size 3;
  - hash_done with hash_in=0xA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D -> result equals it, result_valid=1, busy=0.
- Bytes "abcde" at base 0x200, continuous valid:
  - writes (0x0200, 0x61626364) then (0x0204, 0x65000000);
  - message_size 5.
- "abcd" with byte_valid low for 3 cycles between each byte:
  - single write 0x61626364 at base;
  - no spurious port_A_we during gaps.
- base_addr=0xFFFC, 8 bytes 0x01..0x08:
  - writes (0xFFFC, 0x01020304) and (0x0000, 0x05060708).
- load_start pulsed in FILL and in WAIT_HASH:
  - ignored; message_addr unchanged.
  - hash_done pulsed during FILL: ignored, result_valid stays 0.
- reset asserted after 2 of 6 bytes:
  - outputs 0 immediately, no further writes, no start_hash;
  - a new load_start after reset completes a fresh message normally.
